findmax_deadlock_reporter: RTL

Consumer of the findmax HLS deadlock monitor's block indication. It qualifies the `block` flag as a real deadlock only after it stays high for `THRESHOLD` consecutive cycles, and snapshots which AXIS channel(s) stalled. It then emits one report word over an AXI-Stream-style valid/ready handshake and holds a sticky interrupt until software clears it. It sits beside the findmax kernel, between the monitor and the debug/status path.

---
 rtl/findmax_deadlock_reporter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/findmax_deadlock_reporter.sv
// Qualifies the findmax monitor's block flag over THRESHOLD consecutive cycles,
// then emits one report beat and holds a sticky interrupt until cleared.
module findmax_deadlock_reporter #(
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = 16,
    parameter int NUM_AXIS  = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                block,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    output logic [31:0]         report_tdata,
    output logic                report_tvalid,
    input  logic                report_tready,
    output logic                deadlock_irq,
    input  logic                irq_clear,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        REPORT   = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [NUM_AXIS-1:0] first_mask_reg, first_mask_next;
    logic [NUM_AXIS-1:0] acc_mask_reg, acc_mask_next;
    logic [7:0]          evt_cnt_reg, evt_cnt_next;
    logic [31:0]         tdata_reg, tdata_next;
    logic                tvalid_reg, tvalid_next;
    logic                irq_reg, irq_next;
    logic                busy_reg, busy_next;

    logic [7:0]          evt_inc;
    logic [7:0]          first_mask_ext;
    logic [7:0]          acc_mask_ext;

    assign evt_inc = (evt_cnt_reg == 8'hFF) ? 8'hFF : evt_cnt_reg + 8'd1;

    // Zero-extend the per-channel masks into the fixed 8-bit report fields.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask_ext
            if (gi < NUM_AXIS) begin : g_used
                assign first_mask_ext[gi] = first_mask_next[gi];
                assign acc_mask_ext[gi]   = acc_mask_next[gi];
            end else begin : g_pad
                assign first_mask_ext[gi] = 1'b0;
                assign acc_mask_ext[gi]   = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            first_mask_reg <= '0;
            acc_mask_reg   <= '0;
            evt_cnt_reg    <= '0;
            tdata_reg      <= '0;
            tvalid_reg     <= 1'b0;
            irq_reg        <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            first_mask_reg <= first_mask_next;
            acc_mask_reg   <= acc_mask_next;
            evt_cnt_reg    <= evt_cnt_next;
            tdata_reg      <= tdata_next;
            tvalid_reg     <= tvalid_next;
            irq_reg        <= irq_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        first_mask_next = first_mask_reg;
        acc_mask_next   = acc_mask_reg;
        evt_cnt_next    = evt_cnt_reg;

        case (state_reg)
            IDLE: begin
                cnt_next        = '0;
                first_mask_next = '0;
                acc_mask_next   = '0;
                if (block) begin
                    state_next      = COUNT;
                    cnt_next        = CNT_W'(1);
                    first_mask_next = axis_block_sigs;
                    acc_mask_next   = axis_block_sigs;
                end
            end
            COUNT: begin
                if (block) begin
                    cnt_next      = cnt_reg + CNT_W'(1);
                    acc_mask_next = acc_mask_reg | axis_block_sigs;
                    if (cnt_reg == CNT_W'(THRESHOLD - 1)) begin
                        state_next = REPORT;
                    end
                end else begin
                    state_next      = IDLE;
                    cnt_next        = '0;
                    first_mask_next = '0;
                    acc_mask_next   = '0;
                end
            end
            REPORT: begin
                if (tvalid_reg && report_tready) begin
                    state_next   = WAIT_CLR;
                    evt_cnt_next = evt_inc;
                end
            end
            WAIT_CLR: begin
                if (irq_clear) begin
                    state_next      = IDLE;
                    cnt_next        = '0;
                    first_mask_next = '0;
                    acc_mask_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        tvalid_next = (state_next == REPORT);
        irq_next    = (state_next == WAIT_CLR);
        busy_next   = (state_next != IDLE);
        tdata_next  = '0;
        if (state_next == REPORT) begin
            if (state_reg == REPORT) begin
                tdata_next = tdata_reg;
            end else begin
                tdata_next = {evt_inc, 8'h00, first_mask_ext, acc_mask_ext};
            end
        end
    end

    assign report_tdata  = tdata_reg;
    assign report_tvalid = tvalid_reg;
    assign deadlock_irq  = irq_reg;
    assign busy          = busy_reg;

endmodule
